// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the ThinPad serial-port responder.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 96;
  localparam int unsigned DATA_W               = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: rxd synchroniser, mid-bit sampling FSM, one-cycle valid per good frame.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_byte,
  output logic              valid
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              rxd_s1, rxd_s2, rxd_s3;
  logic              rx_fall;
  uart_state_e       state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;

  assign rx_fall = rxd_s3 & ~rxd_s2;

  // Counter restarts at the start-bit midpoint, so every later full period lands mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      rxd_s3  <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rx_byte <= '0;
      valid   <= 1'b0;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
      valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s2 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {rxd_s2, shift[DATA_W-1:1]};
            if (bit_idx == BIT_LAST) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (rxd_s2) begin
              rx_byte <= shift;
              valid   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_responder.sv
// Device side of the ThinPad serial-port strobe handshake: THR, 8N1 transmitter, RX holding register and flags.
module uart_responder
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdn,
  input  logic              wrn,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              data_ready,
  output logic              tbre,
  output logic              tsre,
  output logic              txd,
  input  logic              rxd,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              rdn_s1, rdn_s2, rdn_s3;
  logic              wrn_s1, wrn_s2, wrn_s3;
  logic              rd_rise, wr_rise;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] thr;
  logic              thr_full;
  uart_state_e       tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_load;
  logic              bit_end;
  logic [DATA_W-1:0] rx_byte;
  logic              rx_valid;

  assign data_oe = ~rdn & rst;
  assign rd_rise = rdn_s2 & ~rdn_s3;
  assign wr_rise = wrn_s2 & ~wrn_s3;
  assign tbre    = ~thr_full;
  assign bit_end = (tx_cnt == CNT_LAST);
  assign tx_load = thr_full & ((tx_state == ST_IDLE) | ((tx_state == ST_STOP) & bit_end));

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_s1 <= 1'b1;
      rdn_s2 <= 1'b1;
      rdn_s3 <= 1'b1;
      wrn_s1 <= 1'b1;
      wrn_s2 <= 1'b1;
      wrn_s3 <= 1'b1;
      shadow <= '0;
    end else begin
      rdn_s1 <= rdn;
      rdn_s2 <= rdn_s1;
      rdn_s3 <= rdn_s2;
      wrn_s1 <= wrn;
      wrn_s2 <= wrn_s1;
      wrn_s3 <= wrn_s2;
      if (!wrn_s1) shadow <= data_in;
    end
  end

  // A commit coinciding with the TX FSM draining the THR refills it instead of being dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr      <= '0;
      thr_full <= 1'b0;
    end else if (wr_rise && (!thr_full || tx_load)) begin
      thr      <= shadow;
      thr_full <= 1'b1;
    end else if (tx_load) begin
      thr_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tsre     <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (thr_full) begin
            tx_shift <= thr;
            tx_cnt   <= '0;
            tsre     <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
            if (tx_bit == BIT_LAST) tx_state <= ST_STOP;
            else                    tx_bit   <= tx_bit + 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            tx_cnt <= '0;
            if (thr_full) begin
              tx_shift <= thr;
              tx_state <= ST_START;
            end else begin
              tsre     <= 1'b1;
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // A byte arriving alongside a read-clear wins, and the read still clears overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else if (rx_valid) begin
      data_out   <= rx_byte;
      data_ready <= 1'b1;
      overrun    <= rd_rise ? 1'b0 : (overrun | data_ready);
    end else if (rd_rise) begin
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .rx_byte (rx_byte),
    .valid   (rx_valid)
  );

endmodule

// File: tb/tb_uart_responder.sv
// Self-checking bench for uart_responder: scripted cases plus random TX/RX traffic against a frame-level model.
module tb_uart_responder;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, data_ready, tbre, tsre, txd, overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .txd        (txd),
    .rxd        (rxd),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line monitor: decodes every 8N1 frame on txd and records its start cycle.
  bit         mon_en = 1'b0;
  logic [7:0] mon_bytes[$];
  int         mon_starts[$];
  int         mon_bad_frame = 0;
  logic [9:0] mon_f;
  int         mon_s;

  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        mon_s = cyc;
        repeat (CPB / 2) @(negedge clk);
        mon_f[0] = txd;
        for (int k = 1; k < 10; k++) begin
          repeat (CPB) @(negedge clk);
          mon_f[k] = txd;
        end
        mon_bytes.push_back(mon_f[8:1]);
        mon_starts.push_back(mon_s);
        if (mon_f[0] !== 1'b0 || mon_f[9] !== 1'b1) mon_bad_frame++;
      end
    end
  end

  function automatic logic pick(input int which);
    case (which)
      0:       return tbre;
      1:       return tsre;
      default: return data_ready;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int limit, input string tag);
    int n = 0;
    while (pick(which) !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (pick(which) !== val) check(tag, 32'(pick(which)), 32'(val));
  endtask

  task automatic cpu_write(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    wrn     = 1'b0;
    repeat (4) @(negedge clk);
    wrn = 1'b1;
    @(negedge clk);
    data_in = 8'($urandom);
    repeat (3) @(negedge clk);
  endtask

  task automatic cpu_read(input string tag);
    @(negedge clk);
    rdn = 1'b0;
    #1 check({tag, "_oe_low"}, 32'(data_oe), 32'd1);
    repeat (3) @(negedge clk);
    rdn = 1'b1;
    #1 check({tag, "_oe_high"}, 32'(data_oe), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rxd = f[k];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] exp_q[$];
  logic [9:0] frame;
  logic [7:0] b;
  logic       stop_ok;
  int         bad_txd, bad_tsre, tbre_rise_cyc, lows;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with rdn held low to show data_oe is masked by reset.
    rdn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tbre", 32'(tbre), 32'd1);
    check("rst_tsre", 32'(tsre), 32'd1);
    check("rst_ready", 32'(data_ready), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_oe", 32'(data_oe), 32'd0);
    check("rst_dout", 32'(data_out), 32'h00);
    rdn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // 0x55: exact edge timing, bit pattern and tsre window.
    frame   = {1'b1, 8'h55, 1'b0};
    data_in = 8'h55;
    wrn     = 1'b0;
    repeat (4) @(negedge clk);
    wrn = 1'b1;
    @(posedge clk) #1;
    check("tbre_edge1", 32'(tbre), 32'd1);
    data_in = 8'($urandom);
    @(posedge clk) #1;
    check("tbre_edge2", 32'(tbre), 32'd1);
    @(posedge clk) #1;
    check("tbre_edge3", 32'(tbre), 32'd0);
    check("tsre_edge3", 32'(tsre), 32'd1);
    @(posedge clk) #1;
    check("tbre_load", 32'(tbre), 32'd1);
    check("tsre_load", 32'(tsre), 32'd0);
    bad_txd  = 0;
    bad_tsre = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (txd !== frame[i / CPB]) bad_txd++;
      if (tsre !== 1'b0) bad_tsre++;
      @(posedge clk) #1;
    end
    check("x55_bits", 32'(bad_txd), 32'd0);
    check("x55_tsre_low80", 32'(bad_tsre), 32'd0);
    check("x55_tsre_rise", 32'(tsre), 32'd1);
    check("x55_txd_idle", 32'(txd), 32'd1);
    repeat (10) @(negedge clk);
    check("x55_mon_count", 32'(mon_bytes.size()), 32'd1);
    if (mon_bytes.size() == 1) check("x55_mon_byte", 32'(mon_bytes[0]), 32'h55);
    mon_bytes.delete();
    mon_starts.delete();

    // Back-to-back A3, 0F, then a third write against a full THR.
    cpu_write(8'hA3);
    wait_for(1, 1'b0, 20, "a3_start_timeout");
    cpu_write(8'h0F);
    check("thr_full_tbre", 32'(tbre), 32'd0);
    cpu_write(8'($urandom));
    tbre_rise_cyc = -1;
    for (int n = 0; n < 200 && tbre_rise_cyc < 0; n++) begin
      if (tbre === 1'b1) tbre_rise_cyc = cyc;
      else @(negedge clk);
    end
    wait_for(1, 1'b1, 300, "b2b_tsre_timeout");
    repeat (30) @(negedge clk);
    check("b2b_count", 32'(mon_bytes.size()), 32'd2);
    if (mon_bytes.size() == 2) begin
      check("b2b_byte0", 32'(mon_bytes[0]), 32'hA3);
      check("b2b_byte1", 32'(mon_bytes[1]), 32'h0F);
      check("b2b_gap", 32'(mon_starts[1] - mon_starts[0]), 32'(10 * CPB));
      check("b2b_tbre_at_load", 32'(tbre_rise_cyc), 32'(mon_starts[1]));
    end
    check("b2b_framing", 32'(mon_bad_frame), 32'd0);
    mon_bytes.delete();
    mon_starts.delete();

    // Random TX with a polling initiator: every byte must leave in order.
    for (int i = 0; i < 6; i++) begin
      wait_for(0, 1'b1, 200, "rnd_tbre_timeout");
      b = 8'($urandom);
      exp_q.push_back(b);
      cpu_write(b);
    end
    wait_for(1, 1'b1, 1000, "rnd_tsre_timeout");
    repeat (20) @(negedge clk);
    check("rnd_tx_count", 32'(mon_bytes.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_bytes.size(); i++)
      check($sformatf("rnd_tx_byte%0d", i), 32'(mon_bytes[i]), 32'(exp_q[i]));
    check("rnd_tx_framing", 32'(mon_bad_frame), 32'd0);
    exp_q.delete();

    // RX 0x3C then read.
    rx_send(8'h3C, 1'b1);
    wait_for(2, 1'b1, 20, "x3c_ready_timeout");
    check("x3c_ready", 32'(data_ready), 32'd1);
    check("x3c_dout", 32'(data_out), 32'h3C);
    cpu_read("x3c");
    check("x3c_cleared", 32'(data_ready), 32'd0);

    // Overrun: two bytes, no read in between.
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_dout", 32'(data_out), 32'h22);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_ready", 32'(data_ready), 32'd1);
    cpu_read("ovr");
    check("ovr_flag_clr", 32'(overrun), 32'd0);
    check("ovr_ready_clr", 32'(data_ready), 32'd0);

    // Two-clock glitch is a false start.
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_ready", 32'(data_ready), 32'd0);

    // Framing error on 0x7E is discarded.
    rx_send(8'h7E, 1'b0);
    repeat (CPB) @(negedge clk);
    check("frame_err_ready", 32'(data_ready), 32'd0);
    check("frame_err_dout", 32'(data_out), 32'h22);

    // Random RX frames, some with a bad stop bit.
    for (int i = 0; i < 6; i++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      rx_send(b, stop_ok);
      if (stop_ok) begin
        wait_for(2, 1'b1, 20, "rnd_rx_timeout");
        check($sformatf("rnd_rx_dout%0d", i), 32'(data_out), 32'(b));
        check($sformatf("rnd_rx_ovr%0d", i), 32'(overrun), 32'd0);
        cpu_read("rnd_rx");
      end else begin
        repeat (4) @(negedge clk);
        check($sformatf("rnd_rx_drop%0d", i), 32'(data_ready), 32'd0);
      end
    end

    // Reset asserted mid-frame.
    mon_en = 1'b0;
    cpu_write(8'h00);
    wait_for(1, 1'b0, 20, "mid_rst_start_timeout");
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_tbre", 32'(tbre), 32'd1);
    check("mid_rst_tsre", 32'(tsre), 32'd1);
    check("mid_rst_ready", 32'(data_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst  = 1'b1;
    lows = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("post_rst_no_frame", 32'(lows), 32'd0);
    check("post_rst_tsre", 32'(tsre), 32'd1);
    mon_bytes.delete();
    mon_starts.delete();
    mon_en = 1'b1;
    b = 8'($urandom);
    cpu_write(b);
    wait_for(1, 1'b0, 20, "post_rst_start_timeout");
    wait_for(1, 1'b1, 200, "post_rst_end_timeout");
    repeat (10) @(negedge clk);
    check("post_rst_count", 32'(mon_bytes.size()), 32'd1);
    if (mon_bytes.size() == 1) check("post_rst_byte", 32'(mon_bytes[0]), 32'(b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_responder.md
# uart_responder

Device-side end of the ThinPad serial-port bus handshake. The CPU's memory stage acts as initiator: it pulses `rdn`/`wrn`, polls `data_ready`/`tbre`/`tsre`, and moves bytes over the low 8 bits of the RAM1 data bus. This block responds to those strobes, serialises written bytes onto `txd` as 8N1, and deserialises `rxd` into a one-byte receive holding register. It replaces the external CPLD bridge so the CPU core and the UART can be built and simulated as one design.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 96: clocks per serial bit (11.0592 MHz / 115200). Minimum 4.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rdn`  in  1  read strobe, active low, asynchronous to `clk`.
- `wrn`  in  1  write strobe, active low, asynchronous to `clk`.
- `data_in`  in  8  byte from the bus during a write.
- `data_out`  out  8  receive holding register.
- `data_oe`  out  1  bus drive enable; the top level tristates `ram1_data[7:0]` with it.
- `data_ready`  out  1  receive holding register full.
- `tbre`  out  1  transmit holding register empty.
- `tsre`  out  1  transmit shifter and line idle.
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input, asynchronous.
- `overrun`  out  1  sticky: a received byte overwrote an unread one.

## Operation
- Reset values: `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `overrun`=0, `data_oe`=0, `data_out`=0x00. Both state machines go to IDLE.
- `rdn`, `wrn` and `rxd` each pass through a 2-flop synchroniser. Edges are detected on the second stage.
- Read:
  - `data_oe` = ~`rdn` combinationally, forced to 0 while `rst` is low, so the bus is driven with no synchroniser latency.
  - On the synchronised rising edge of `rdn`, clear `data_ready` and `overrun`.
- Write:
  - A shadow register loads `data_in` on every clk while the first-stage `wrn` is low.
  - On the synchronised rising edge of `wrn`, the shadow register moves to the transmit holding register (THR) and `tbre` drops.
  - If the THR is already full, the write is dropped and the THR is unchanged.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - In IDLE with the THR full: load the shifter from the THR, set `tbre`=1 and `tsre`=0, go to START.
  - START drives 0, DATA drives 8 bits LSB first, STOP drives 1. Each bit lasts `CLKS_PER_BIT` clocks.
  - At the end of STOP: if the THR is full, go straight to START with the new byte, with no idle gap. Otherwise set `tsre`=1 and go to IDLE.
- RX FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE waits for a falling edge on synchronised `rxd`.
  - START samples at mid-bit (`CLKS_PER_BIT`/2). If `rxd` is high there, it is a false start: return to IDLE.
  - DATA samples 8 bits, one every `CLKS_PER_BIT` clocks, LSB first.
  - At the STOP mid-bit sample:
    - If `rxd`=1: write `data_out`, set `data_ready`, and set `overrun` if `data_ready` was already 1.
    - If `rxd`=0 (framing error): discard the byte and leave the flags unchanged.
    - Either way, return to IDLE.
- Simultaneous events:
  - A byte completing in the same cycle as a read-clear: the new byte wins, `data_ready` stays 1, and `overrun`=0.
  - A write commit in the same cycle the TX FSM empties the THR: the THR takes the new byte and `tbre` stays 0.
- Reset asserted mid-frame: the FSMs return to IDLE immediately and `txd`=1. A partial frame is lost.

## Timing
- `wrn` rising at the pin → THR loaded and `tbre`=0 on the 3rd clk edge (2 synchroniser stages plus 1 edge-detect stage).
- TX idle: START is entered 1 clk after the THR load, and `tbre` returns to 1 in that same cycle.
- Frame length is 10×`CLKS_PER_BIT` clocks. `tsre` rises 1 clk after the STOP bit ends.
- RX: `data_ready` rises 3 clk after the STOP mid-bit point on the pin (2 synchroniser stages plus 1 registered update).
- Initiator requirements:
  - Hold `wrn` low for at least 2 clk, with `data_in` stable throughout.
  - Hold `rdn` low for at least 2 clk so the clear edge is seen.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT` default.
  - TX/RX state encodings (2 bits: IDLE, START, DATA, STOP).
  - Data width of 8.
- Sub-module `uart_rx_core`: RX synchroniser, FSM and bit counter, exporting a byte and a `valid` pulse.
- The top level holds the strobe synchronisers, THR, TX FSM and flags.

## Test plan
- Reset, with `rst` held low mid-TX: `txd`=1, `tbre`=`tsre`=1, `data_ready`=0, `data_oe`=0. After release, no spurious frame appears.
- Write 0x55 (`wrn` low for 4 clk), `CLKS_PER_BIT`=8:
  - `txd` shows 0,1,0,1,0,1,0,1,0,1 with 8 clk per bit.
  - `tsre` is low for 80 clk, then high.
- Write 0xA3, then 0x0F during the 0xA3 frame, then a third write while the THR is full:
  - Frames for 0xA3 and 0x0F go out back to back with no gap.
  - The third byte is dropped and `tbre` stays 0 until the second load.
- Drive an `rxd` frame for 0x3C:
  - `data_ready`=1 with `data_out`=0x3C.
  - A `rdn` pulse shows `data_oe`=1 while low, and `data_ready`=0 after the rising edge.
- Two frames, 0x11 then 0x22, with no read in between: `data_out`=0x22 and `overrun`=1. Both clear on read.
- Edge cases on `rxd`:
  - A 2-clk low glitch is a false start: no byte is received.
  - A frame for 0x7E with the stop bit at 0 is discarded: `data_ready` stays 0.
